instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the uPower instruction memory: accepts a byte stream (e.g. from a UART/host bridge) and packs it into 32-bit big-endian instruction words.
- Writes each word into the instruction memory at consecutive word indices starting at 0. These are the same indices the program counter uses to fetch.
- Sits between the host byte source and the instruction memory write port. Signals done once the requested number of words is stored.

Parameters:
- DEPTH, 64, number of instruction words in the target memory. Legal word indices are 0..DEPTH-1.
- AW, 32, width of mem_addr. Matches the program_counter width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load. Sampled only in IDLE or DONE.
- num_words  in  AW  number of words to load. Latched on an accepted start.
- in_valid  in  1  byte source has a byte on in_data.
- in_data  in  8  stream byte; first byte of each word is the MSB.
- in_ready  out  1  loader will consume in_data this cycle.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  AW  word index of the write.
- mem_wdata  out  32  instruction word being written.
- busy  out  1  load in progress.
- done  out  1  last load completed.
- error  out  1  last start was rejected because num_words > DEPTH.
- words_written  out  AW  count of words committed in the current/last load.

Behaviour:
- Reset: all outputs 0 and state IDLE. Byte counter, word shift register and latched count are cleared.
  - Reset mid-load discards the partial word. Memory words already written are not touched.
  - The next load starts cleanly at index 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE, start=1:
  - num_words > DEPTH: error=1, done=0, stay in IDLE, no writes.
  - num_words == 0: go to DONE next cycle with done=1, error=0, words_written=0, no writes.
  - Otherwise: latch count, mem_addr=0, words_written=0, byte counter=0, done=0, error=0, busy=1, go to LOAD.
- start while busy=1 is ignored, with no effect on any output.
- LOAD:
  - in_ready=1. A byte is accepted only when in_valid && in_ready; otherwise the shift register holds.
  - On accept: word <= {word[23:0], in_data}, byte counter increments mod 4.
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_wdata=assembled word, mem_addr=current index, in_ready=0.
  - The write strobe occurs the cycle after the 4th byte handshake.
  - words_written increments at the end of this cycle.
  - If index == count-1, go to DONE. Else mem_addr+1 and return to LOAD.
- Throughput: one word per 5 cycles at best (4 bytes + 1 write cycle).
- DONE: busy=0, done=1 held, in_ready=0, mem_we=0. mem_addr holds the last written index. Only start or reset leave DONE.
- mem_we is 0 in every state except WRITE. mem_wdata and mem_addr are stable during mem_we.
- Bytes offered outside LOAD are never consumed (in_ready=0). Extra bytes after the last word remain unconsumed.
- Address never exceeds DEPTH-1; no wrap-around is possible because num_words is range-checked at start.

Decomposition:
- Package upower_loader_pkg:
  - loader_state_t enum (IDLE, LOAD, WRITE, DONE)
  - BYTES_PER_WORD=4
  - INSTR_W=32
- Sub-module byte_packer: owns the 32-bit shift register and the 2-bit byte counter.
  - Inputs: clk, reset, clear, accept, in_data.
  - Outputs: word, word_full.
- The FSM, address counter and handshake live in instruction_loader.

Test Plan:
- Basic load, num_words=2, bytes 7C 22 1A 14 38 40 00 05 with in_valid always high:
  - mem_we at addr 0 with 0x7C221A14, then addr 1 with 0x38400005.
  - Each strobe comes 1 cycle after its 4th byte.
  - done=1, words_written=2, busy=0.
  - Read-back through the instruction memory model returns both words at indices 0 and 1.
- Bubbles, in_valid toggling 1/0 each cycle over the same 8 bytes: identical writes and data; no byte duplicated or dropped.
- num_words=0: done=1 one cycle after start; mem_we never asserted; error=0.
- num_words=DEPTH+1 (65):
  - error=1, busy stays 0, no mem_we.
  - A following start with num_words=1 clears error and loads normally.
- Reset after 2 of 4 bytes (AA BB): all outputs return to 0. A new start with num_words=1 and bytes 01 02 03 04 writes 0x01020304 at addr 0, with no AA/BB residue.
- start pulsed during LOAD with num_words=5: ignored; the original load of 2 words completes with words_written=2.

Source files
------------

// File: rtl/upower_loader_pkg.sv
// rtl/upower_loader_pkg.sv - shared types and constants for the instruction loader
//
// Purpose: loader FSM state encoding and instruction word geometry.
// Ports:   none (package).
`timescale 1ns/1ps
package upower_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W        = 32;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - big-endian byte to 32-bit word packer
//
// Purpose: shifts accepted bytes into a word, first byte ending up as the MSB.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   clear       - drop any partial word and restart the byte count
//   accept      - a byte handshake happens this cycle
//   in_data     - byte to shift in when accept is high
//   word        - assembled word (valid once word_full has fired)
//   word_full   - this accept completes the word
`timescale 1ns/1ps
module byte_packer
  import upower_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         in_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      word     <= {word[INSTR_W-9:0], in_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Combinational so the FSM can enter WRITE right after the 4th handshake;
  // the counter wraps to 0 on that same edge, ready for the next word.
  assign word_full = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte stream to instruction memory writer
//
// Purpose: packs a byte stream into 32-bit big-endian words and writes them
//          to consecutive instruction memory indices starting at 0.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   start          - request a load (honoured only in IDLE or DONE)
//   num_words      - words to load, latched on an accepted start
//   in_valid       - byte source has a byte on in_data
//   in_data        - stream byte, MSB first within each word
//   in_ready       - loader consumes in_data this cycle
//   mem_we         - one-cycle memory write strobe
//   mem_addr       - word index of the write
//   mem_wdata      - word being written
//   busy           - load in progress
//   done           - last load completed
//   error          - last start rejected (num_words > DEPTH)
//   words_written  - words committed in the current/last load
`timescale 1ns/1ps
module instruction_loader
  import upower_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [AW-1:0]      num_words,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [AW-1:0]      words_written
);

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  loader_state_t      state, next_state;
  logic [AW-1:0]      count;
  logic [INSTR_W-1:0] word;
  logic               word_full;
  logic               accept;
  logic               start_ok;
  logic               too_many;
  logic               zero_len;
  logic               load_go;
  logic               last_word;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign too_many  = num_words > DEPTH_W;
  assign zero_len  = (num_words == '0);
  assign load_go   = start_ok && !too_many && !zero_len;
  assign accept    = in_valid && in_ready;
  assign last_word = (mem_addr == count - AW'(1));

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_go),
    .accept    (accept),
    .in_data   (in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          if (too_many) begin
            next_state = IDLE;
          end else if (zero_len) begin
            next_state = DONE;
          end else begin
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_full) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        next_state = last_word ? DONE : LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    mem_we    = (state == WRITE);
    busy      = (state == LOAD) || (state == WRITE);
    done      = (state == DONE);
    mem_wdata = (state == WRITE) ? word : '0;
  end

  // Count, index and status registers. A rejected start only raises error;
  // the previous load's words_written and mem_addr stay visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      mem_addr      <= '0;
      words_written <= '0;
      error         <= 1'b0;
    end else begin
      if (start_ok) begin
        if (too_many) begin
          error <= 1'b1;
        end else begin
          error         <= 1'b0;
          count         <= num_words;
          mem_addr      <= '0;
          words_written <= '0;
        end
      end
      if (state == WRITE) begin
        words_written <= words_written + AW'(1);
        // Hold the index on the last word so DONE shows the final address.
        if (!last_word) begin
          mem_addr <= mem_addr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
`timescale 1ns/1ps
module tb_instruction_loader;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic        start;
    logic [31:0] nw;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ww;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] words_written;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [0:63];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] max_addr;

  vec_t tbl [12];

  always #5 clk = ~clk;

  instruction_loader #(.DEPTH(64), .AW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_words     (num_words),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  // Instruction memory model plus a log of every write strobe.
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < 32'd64) mem_model[mem_addr[5:0]] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      if (mem_addr > max_addr) max_addr <= mem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    max_addr = 32'd0;
  endtask

  // Drive one cycle of inputs, report whether a byte handshake occurs, then
  // return #1 after the rising edge with outputs settled.
  task automatic cycle(input logic s, input logic [31:0] nw, input logic v,
                       input logic [7:0] d, output bit hs);
    start = s; num_words = nw; in_valid = v; in_data = d;
    #1;
    hs = in_valid && in_ready;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Offer bytes as a stream source would (held until consumed) until done,
  // optionally with bubbles and a stray start pulse at cycle start_at.
  task automatic feed(input byte_q_t bq, input bit bubbles, input int start_at,
                      input logic [31:0] start_nw, input string name, output int consumed);
    int  idx;
    bit  fin;
    bit  hs;
    logic s, v;
    idx = 0; fin = 0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      s = (k == start_at);
      v = (idx < bq.size()) && (!bubbles || (k % 2 == 0));
      cycle(s, s ? start_nw : 32'd0, v, v ? bq[idx] : 8'h00, hs);
      if (hs) idx++;
      if (done) fin = 1;
    end
    consumed = idx;
    chk1({name, " reached done"}, done, 1'b1);
  endtask

  initial begin
    byte_q_t q;
    int      n;
    bit      hs;
    reset = 1'b0; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    max_addr = '0;
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;

    // Basic two-word load, in_valid high; expected values are post-edge.
    tbl[0]  = '{1'b1, 32'd2, 1'b0, 8'h00, 1'b1, 1'b0, 32'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 32'd0, 1'b1, 8'h7C, 1'b1, 1'b0, 32'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 32'd0, 1'b1, 8'h22, 1'b1, 1'b0, 32'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 32'd0, 1'b1, 8'h1A, 1'b1, 1'b0, 32'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd0};
    tbl[4]  = '{1'b0, 32'd0, 1'b1, 8'h14, 1'b0, 1'b1, 32'd0, 32'h7C221A14, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[5]  = '{1'b0, 32'd0, 1'b1, 8'h38, 1'b1, 1'b0, 32'd1, 32'h0,        1'b1, 1'b0, 1'b0, 32'd1};
    tbl[6]  = '{1'b0, 32'd0, 1'b1, 8'h38, 1'b1, 1'b0, 32'd1, 32'h0,        1'b1, 1'b0, 1'b0, 32'd1};
    tbl[7]  = '{1'b0, 32'd0, 1'b1, 8'h40, 1'b1, 1'b0, 32'd1, 32'h0,        1'b1, 1'b0, 1'b0, 32'd1};
    tbl[8]  = '{1'b0, 32'd0, 1'b1, 8'h00, 1'b1, 1'b0, 32'd1, 32'h0,        1'b1, 1'b0, 1'b0, 32'd1};
    tbl[9]  = '{1'b0, 32'd0, 1'b1, 8'h05, 1'b0, 1'b1, 32'd1, 32'h38400005, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[10] = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'd1, 32'h0,        1'b0, 1'b1, 1'b0, 32'd2};
    tbl[11] = '{1'b0, 32'd0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'd1, 32'h0,        1'b0, 1'b1, 1'b0, 32'd2};

    do_reset();
    do_reset();
    chk1("reset in_ready", in_ready, 1'b0);
    chk1("reset mem_we", mem_we, 1'b0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset error", error, 1'b0);
    chk("reset words_written", words_written, 32'd0);

    clear_log();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].start, tbl[i].nw, tbl[i].v, tbl[i].d, hs);
      chk1($sformatf("v%0d in_ready", i), in_ready, tbl[i].rdy);
      chk1($sformatf("v%0d mem_we", i), mem_we, tbl[i].we);
      chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].addr);
      if (tbl[i].we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].wdata);
      chk1($sformatf("v%0d busy", i), busy, tbl[i].busy);
      chk1($sformatf("v%0d done", i), done, tbl[i].done);
      chk1($sformatf("v%0d error", i), error, tbl[i].err);
      chk($sformatf("v%0d words_written", i), words_written, tbl[i].ww);
    end
    chk("basic readback 0", mem_model[0], 32'h7C221A14);
    chk("basic readback 1", mem_model[1], 32'h38400005);
    chk("basic write count", wr_addr_q.size(), 32'd2);

    // Bubbles: in_valid toggles, same bytes, same result.
    clear_log();
    mem_model[0] = 32'h0; mem_model[1] = 32'h0;
    cycle(1'b1, 32'd2, 1'b0, 8'h00, hs);
    q = '{8'h7C, 8'h22, 8'h1A, 8'h14, 8'h38, 8'h40, 8'h00, 8'h05};
    feed(q, 1'b1, -1, 32'd0, "bubbles", n);
    chk("bubbles bytes consumed", n, 32'd8);
    chk("bubbles write count", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("bubbles addr0", wr_addr_q[0], 32'd0);
      chk("bubbles data0", wr_data_q[0], 32'h7C221A14);
      chk("bubbles addr1", wr_addr_q[1], 32'd1);
      chk("bubbles data1", wr_data_q[1], 32'h38400005);
    end
    chk("bubbles readback 1", mem_model[1], 32'h38400005);
    chk("bubbles words_written", words_written, 32'd2);

    // Start pulsed during LOAD is ignored.
    clear_log();
    cycle(1'b1, 32'd2, 1'b0, 8'h00, hs);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    feed(q, 1'b0, 2, 32'd5, "start in load", n);
    chk("start in load words_written", words_written, 32'd2);
    chk("start in load write count", wr_addr_q.size(), 32'd2);
    chk1("start in load busy", busy, 1'b0);
    if (wr_data_q.size() == 2) chk("start in load data1", wr_data_q[1], 32'h55667788);

    // Oversize request rejected, then a normal one-word load.
    clear_log();
    cycle(1'b1, 32'd65, 1'b1, 8'h99, hs);
    chk1("oversize error", error, 1'b1);
    chk1("oversize done", done, 1'b0);
    chk1("oversize busy", busy, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 8'h99, hs);
    cycle(1'b0, 32'd0, 1'b1, 8'h99, hs);
    chk1("oversize in_ready", in_ready, 1'b0);
    chk1("oversize busy later", busy, 1'b0);
    chk("oversize no writes", wr_addr_q.size(), 32'd0);
    cycle(1'b1, 32'd1, 1'b0, 8'h00, hs);
    chk1("restart error cleared", error, 1'b0);
    chk1("restart busy", busy, 1'b1);
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    feed(q, 1'b0, -1, 32'd0, "restart", n);
    chk("restart write count", wr_addr_q.size(), 32'd1);
    chk("restart readback", mem_model[0], 32'hDEADBEEF);
    chk("restart words_written", words_written, 32'd1);

    // Full-depth load: last index is DEPTH-1, never beyond.
    clear_log();
    q.delete();
    for (int i = 0; i < 64; i++) begin
      q.push_back(8'(i)); q.push_back(8'hA5); q.push_back(~8'(i)); q.push_back(8'h3C);
    end
    cycle(1'b1, 32'd64, 1'b0, 8'h00, hs);
    chk1("depth accepted", error, 1'b0);
    feed(q, 1'b0, -1, 32'd0, "depth", n);
    chk("depth write count", wr_addr_q.size(), 32'd64);
    chk("depth max addr", max_addr, 32'd63);
    chk("depth mem_addr", mem_addr, 32'd63);
    chk("depth words_written", words_written, 32'd64);
    chk("depth readback 63", mem_model[63], 32'h3FA5C03C);
    chk("depth readback 17", mem_model[17], 32'h11A5EE3C);

    // Reset after two bytes discards the partial word.
    clear_log();
    cycle(1'b1, 32'd1, 1'b0, 8'h00, hs);
    cycle(1'b0, 32'd0, 1'b1, 8'hAA, hs);
    cycle(1'b0, 32'd0, 1'b1, 8'hBB, hs);
    do_reset();
    chk1("midreset in_ready", in_ready, 1'b0);
    chk1("midreset mem_we", mem_we, 1'b0);
    chk("midreset mem_addr", mem_addr, 32'd0);
    chk("midreset mem_wdata", mem_wdata, 32'd0);
    chk1("midreset busy", busy, 1'b0);
    chk1("midreset done", done, 1'b0);
    chk1("midreset error", error, 1'b0);
    chk("midreset words_written", words_written, 32'd0);
    cycle(1'b1, 32'd1, 1'b0, 8'h00, hs);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    feed(q, 1'b0, -1, 32'd0, "after reset", n);
    chk("after reset write count", wr_addr_q.size(), 32'd1);
    if (wr_data_q.size() == 1) begin
      chk("after reset addr", wr_addr_q[0], 32'd0);
      chk("after reset data", wr_data_q[0], 32'h01020304);
    end

    // Zero-length load from IDLE.
    do_reset();
    clear_log();
    chk1("zero pre done", done, 1'b0);
    cycle(1'b1, 32'd0, 1'b1, 8'h55, hs);
    chk1("zero done", done, 1'b1);
    chk1("zero error", error, 1'b0);
    chk1("zero busy", busy, 1'b0);
    chk1("zero in_ready", in_ready, 1'b0);
    chk("zero words_written", words_written, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 8'h55, hs);
    chk1("zero done held", done, 1'b1);
    chk("zero no writes", wr_addr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
